uart_rx: RTL and testbench

Serial-to-parallel UART receiver, the receive-side counterpart of the transmitter's start/data/parity/stop bit sequencing. It synchronises the asynchronous `rx_in` line, detects a start bit, and samples each bit at mid-bit. It delivers the byte with a one-cycle valid strobe plus parity and framing error flags. The frame format is 1 start bit, 8 data bits LSB first, an optional parity bit, and 1 stop bit.

---
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchroniser, falling-edge start detect and mid-bit sampling.
// Frame is 1 start, 8 data bits LSB first, optional parity, 1 stop; registered byte, strobe and flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic             sync1_q, rx_s_q, rx_d_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_err_q, par_err_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;

  // Synchroniser resets to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // Falling edge only: a line held low never re-arms reception.
        if (rx_d_q && !rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_err_d = (^shift_q) ^ rx_s_q ^ PARITY_ODD;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at mid-stop so a start edge half a bit later is still caught.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = PARITY_EN ? par_err_q : 1'b0;
          ferr_d  = ~rx_s_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      // NOTE: the shift register is reset too; it is small and feeds a visible output.
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: even-parity, odd-parity and no-parity instances,
// vector table, hand-written corner sequences and a randomized run against a frame-level model.
module tb_uart_rx;
  localparam int N = 16;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_a, rx_b;
  logic [7:0] dout_e, dout_o, dout_n;
  logic       dv_e, dv_o, dv_n;
  logic       pe_e, pe_o, pe_n;
  logic       fe_e, fe_o, fe_n;
  logic       bz_e, bz_o, bz_n;

  uart_rx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .rx_in(rx_a), .data_out(dout_e), .data_valid(dv_e),
    .parity_err(pe_e), .frame_err(fe_e), .busy(bz_e));
  uart_rx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .rx_in(rx_a), .data_out(dout_o), .data_valid(dv_o),
    .parity_err(pe_o), .frame_err(fe_o), .busy(bz_o));
  uart_rx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
    .clk(clk), .reset(reset), .rx_in(rx_b), .data_out(dout_n), .data_valid(dv_n),
    .parity_err(pe_n), .frame_err(fe_n), .busy(bz_n));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         at;
  } evt_t;

  evt_t q_e[$], q_o[$], q_n[$];
  int rd_e = 0, rd_o = 0, rd_n = 0;

  always @(negedge clk) begin
    if (dv_e) q_e.push_back('{data: dout_e, perr: pe_e, ferr: fe_e, at: cyc});
    if (dv_o) q_o.push_back('{data: dout_o, perr: pe_o, ferr: fe_o, at: cyc});
    if (dv_n) q_n.push_back('{data: dout_n, perr: pe_n, ferr: fe_n, at: cyc});
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit line_b, input logic v);
    if (line_b) rx_b = v;
    else        rx_a = v;
  endtask

  task automatic send(input bit line_b, input logic [7:0] b, input logic par, input logic stop,
                      input bit with_par, output int fall);
    fall = cyc;
    drive(line_b, 1'b0);
    tick(N);
    for (int i = 0; i < 8; i++) begin
      drive(line_b, b[i]);
      tick(N);
    end
    if (with_par) begin
      drive(line_b, par);
      tick(N);
    end
    drive(line_b, stop);
    tick(N);
    drive(line_b, 1'b1);
  endtask

  // which: 0 = even instance, 1 = odd instance, 2 = no-parity instance; at < 0 skips timing.
  task automatic expect_evt(input string tag, input int which, input logic [7:0] d, input logic pe,
                            input logic fe, input int at, output int got_at);
    evt_t e;
    bit   got;
    got    = 1'b0;
    got_at = -1;
    e      = '{data: 8'h00, perr: 1'b0, ferr: 1'b0, at: 0};
    case (which)
      0: if (rd_e < q_e.size()) begin e = q_e[rd_e]; rd_e++; got = 1'b1; end
      1: if (rd_o < q_o.size()) begin e = q_o[rd_o]; rd_o++; got = 1'b1; end
      default: if (rd_n < q_n.size()) begin e = q_n[rd_n]; rd_n++; got = 1'b1; end
    endcase
    check({tag, " valid seen"}, 32'(got), 32'd1);
    if (got) begin
      got_at = e.at;
      check({tag, " data"}, 32'(e.data), 32'(d));
      check({tag, " parity_err"}, 32'(e.perr), 32'(pe));
      check({tag, " frame_err"}, 32'(e.ferr), 32'(fe));
      if (at >= 0) check_near({tag, " latency"}, e.at, at, 1);
    end
  endtask

  task automatic expect_pair(input string tag, input logic [7:0] d, input logic pe_even,
                             input logic pe_odd, input logic fe, input int at);
    int dummy;
    expect_evt({tag, " even"}, 0, d, pe_even, fe, at, dummy);
    expect_evt({tag, " odd"}, 1, d, pe_odd, fe, at, dummy);
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, " extra valid even"}, 32'(q_e.size() - rd_e), 32'd0);
    check({tag, " extra valid odd"}, 32'(q_o.size() - rd_o), 32'd0);
    check({tag, " extra valid nopar"}, 32'(q_n.size() - rd_n), 32'd0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       par;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe_even;
    logic       exp_pe_odd;
    logic       exp_fe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pe_even;
    logic       pe_odd;
    logic       fe;
    int         at;
  } exp_t;

  vec_t vecs[7];
  exp_t exp_q[$];

  initial begin
    int fall, f1, f2, f3, a1, a2, a3, gap;
    logic seen_busy, busy_end;
    logic [7:0] b, rb;
    logic par, stop;

    vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'h96, 1'b1, 1'b0, 8'h96, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    tick(3);
    check("reset data_out", 32'(dout_e), 32'h00);
    check("reset data_valid", 32'(dv_e), 32'd0);
    check("reset parity_err", 32'(pe_e), 32'd0);
    check("reset frame_err", 32'(fe_e), 32'd0);
    check("reset busy", 32'(bz_e), 32'd0);
    check("reset busy odd", 32'(bz_o), 32'd0);
    check("reset busy nopar", 32'(bz_n), 32'd0);
    reset = 1'b0;
    tick(2);

    // Vector table on the parity instances.
    for (int i = 0; i < 7; i++) begin
      send(1'b0, vecs[i].b, vecs[i].par, vecs[i].stop, 1'b1, fall);
      tick(2 * N);
      expect_pair($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_pe_even,
                  vecs[i].exp_pe_odd, vecs[i].exp_fe, fall + 3 + H + 10 * N);
    end

    // Glitch of 3 clocks, then a clean 0x00.
    fall = cyc;
    drive(1'b0, 1'b0);
    tick(3);
    drive(1'b0, 1'b1);
    seen_busy = 1'b0;
    busy_end  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (cyc == fall + 3)  seen_busy = bz_e;
      if (cyc == fall + 11) busy_end  = bz_e;
    end
    check("glitch busy raised", 32'(seen_busy), 32'd1);
    check("glitch busy dropped", 32'(busy_end), 32'd0);
    tick(2 * N);
    expect_quiet("glitch");
    send(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, fall);
    tick(2 * N);
    expect_pair("after glitch", 8'h00, 1'b0, 1'b1, 1'b0, fall + 3 + H + 10 * N);

    // Framing error followed by a 40-bit break.
    send(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, fall);
    drive(1'b0, 1'b0);
    tick(40 * N);
    check("break busy", 32'(bz_e), 32'd0);
    expect_pair("break frame", 8'h0F, 1'b0, 1'b1, 1'b1, fall + 3 + H + 10 * N);
    expect_quiet("during break");
    drive(1'b0, 1'b1);
    tick(2 * N);
    expect_quiet("break release");
    send(1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, fall);
    tick(2 * N);
    expect_pair("after break", 8'h5A, 1'b0, 1'b1, 1'b0, fall + 3 + H + 10 * N);

    // Back-to-back frames with no idle on the no-parity instance.
    send(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, f1);
    send(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, f2);
    send(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, f3);
    tick(2 * N);
    expect_evt("b2b 0", 2, 8'h01, 1'b0, 1'b0, f1 + 3 + H + 9 * N, a1);
    expect_evt("b2b 1", 2, 8'h80, 1'b0, 1'b0, f2 + 3 + H + 9 * N, a2);
    expect_evt("b2b 2", 2, 8'hFF, 1'b0, 1'b0, f3 + 3 + H + 9 * N, a3);
    check("b2b spacing 01", 32'(a2 - a1), 32'(10 * N));
    check("b2b spacing 12", 32'(a3 - a2), 32'(10 * N));

    // Reset pulse in the middle of bit 4 of 0x3C; the transmitter then abandons the frame.
    b = 8'h3C;
    drive(1'b0, 1'b0);
    tick(N);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, b[i]);
      tick(N);
    end
    drive(1'b0, b[4]);
    tick(H);
    check("pre-reset busy", 32'(bz_e), 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid reset data_out", 32'(dout_e), 32'h00);
    check("mid reset busy", 32'(bz_e), 32'd0);
    check("mid reset data_valid", 32'(dv_e), 32'd0);
    check("mid reset parity_err odd", 32'(pe_o), 32'd0);
    check("mid reset data_out nopar", 32'(dout_n), 32'h00);
    drive(1'b0, 1'b1);
    tick(12 * N);
    expect_quiet("truncated frame");
    send(1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, fall);
    tick(2 * N);
    expect_pair("after reset", 8'hC3, 1'b0, 1'b1, 1'b0, fall + 3 + H + 10 * N);

    // Randomized frames; the model works at frame level from the bit rules.
    for (int i = 0; i < 24; i++) begin
      rb   = 8'($urandom);
      par  = 1'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send(1'b0, rb, par, stop, 1'b1, fall);
      exp_q.push_back('{d: rb, pe_even: (^rb) ^ par, pe_odd: ~((^rb) ^ par), fe: ~stop,
                        at: fall + 3 + H + 10 * N});
      if (gap > 0) tick(gap * N);
    end
    tick(2 * N);
    foreach (exp_q[i])
      expect_pair($sformatf("rand%0d", i), exp_q[i].d, exp_q[i].pe_even, exp_q[i].pe_odd,
                  exp_q[i].fe, exp_q[i].at);
    expect_quiet("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
